// File: rtl/switch_share_arbiter.sv
// Two debounced switch requesters sharing one output through a round-robin arbiter with a minimum hold.
// Optional SWITCH_SHARE_ARB_SYNC_EN adds a 2-flop synchronizer on each raw input ahead of debounce.
module switch_share_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_HOLD        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_a,
  input  logic in_b,
  output logic out,
  output logic grant_a,
  output logic grant_b,
  output logic req_a,
  output logic req_b
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  logic [1:0] raw, samp;
  assign raw = {in_b, in_a};

`ifdef SWITCH_SHARE_ARB_SYNC_EN
  logic [1:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end
  assign samp = sync2_q;
`else
  assign samp = raw;
`endif

  // Index 0 is requester A, index 1 is requester B.
  logic [1:0]         req_q, req_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    req_d = req_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (samp[i] == req_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        req_d[i] = samp[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_b_q, last_b_d;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (req_q[0] && (!req_q[1] || last_b_q)) state_d = GNT_A;
        else if (req_q[1])                       state_d = GNT_B;
      end
      GNT_A: begin
        if (!req_q[0])                               state_d = req_q[1] ? GNT_B : IDLE;
        else if (hold_q == HOLD_LAST && req_q[1])    state_d = GNT_B;
        else if (hold_q != HOLD_LAST)                hold_d  = hold_q + HW'(1);
      end
      GNT_B: begin
        if (!req_q[1])                               state_d = req_q[0] ? GNT_A : IDLE;
        else if (hold_q == HOLD_LAST && req_q[0])    state_d = GNT_A;
        else if (hold_q != HOLD_LAST)                hold_d  = hold_q + HW'(1);
      end
      default: state_d = IDLE;
    endcase
    // Any new ownership restarts the hold window and records the owner for round-robin.
    if (state_d != state_q && state_d != IDLE) begin
      hold_d   = '0;
      last_b_d = (state_d == GNT_B);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      hold_q   <= '0;
      last_b_q <= 1'b1;
    end else begin
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      hold_q   <= hold_d;
      last_b_q <= last_b_d;
    end
  end

  assign req_a   = req_q[0];
  assign req_b   = req_q[1];
  assign grant_a = (state_q == GNT_A);
  assign grant_b = (state_q == GNT_B);
  assign out     = (state_q != IDLE);

endmodule

// File: tb/tb_switch_share_arbiter.sv
// Randomized scoreboard bench for switch_share_arbiter against a cycle-level behavioural model.
module tb_switch_share_arbiter;
  localparam int DB = 4;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_a = 1'b0;
  logic in_b = 1'b0;
  logic out, grant_a, grant_b, req_a, req_b;

  switch_share_arbiter #(.DEBOUNCE_CYCLES(DB), .MIN_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b),
    .out(out), .grant_a(grant_a), .grant_b(grant_b),
    .req_a(req_a), .req_b(req_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic req_a, req_b, grant_a, grant_b, out;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Model: debounced levels, run length of disagreeing samples, owner (0 none, 1 A, 2 B),
  // cycles since ownership began, and the most recently served requester.
  int m_req[2]  = '{0, 0};
  int m_run[2]  = '{0, 0};
  int m_s1[2]   = '{0, 0};
  int m_s2[2]   = '{0, 0};
  int m_owner   = 0;
  int m_age     = 0;
  int m_last    = 2;

  task automatic give(input int who);
    m_owner = who;
    m_age   = 0;
    m_last  = who;
  endtask

  task automatic model_edge(input logic r, input logic a, input logic b);
    int   raw[2];
    int   smp[2];
    int   oreq[2];
    int   other;
    exp_t e;
    raw[0] = int'(a);
    raw[1] = int'(b);
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_req[i] = 0; m_run[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      end
      m_owner = 0; m_age = 0; m_last = 2;
    end else begin
      for (int i = 0; i < 2; i++) begin
`ifdef SWITCH_SHARE_ARB_SYNC_EN
        smp[i] = m_s2[i];
`else
        smp[i] = raw[i];
`endif
        oreq[i] = m_req[i];
      end
      for (int i = 0; i < 2; i++) begin
        if (smp[i] == m_req[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_req[i] = smp[i];
            m_run[i] = 0;
          end
        end
      end
      if (m_owner == 0) begin
        if (oreq[0] != 0 && oreq[1] != 0) give(m_last == 1 ? 2 : 1);
        else if (oreq[0] != 0)            give(1);
        else if (oreq[1] != 0)            give(2);
      end else begin
        other = 3 - m_owner;
        if (oreq[m_owner-1] == 0) begin
          if (oreq[other-1] != 0) give(other);
          else m_owner = 0;
        end else if (m_age >= MH - 1 && oreq[other-1] != 0) give(other);
        else m_age++;
      end
      for (int i = 0; i < 2; i++) begin
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
    e.req_a   = (m_req[0] != 0);
    e.req_b   = (m_req[1] != 0);
    e.grant_a = (m_owner == 1);
    e.grant_b = (m_owner == 2);
    e.out     = (m_owner != 0);
    q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic a, input logic b);
    @(negedge clk);
    rst  = r;
    in_a = a;
    in_b = b;
    model_edge(r, a, b);
  endtask

  initial begin : monitor
    exp_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = '{req_a, req_b, grant_a, grant_b, out};
        n_cmp++;
        if (act !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t {req_a,req_b,grant_a,grant_b,out} got=%b want=%b",
                   $time, act, e);
        end
      end
    end
  end

  initial begin : stim
    logic [4:0] bounce;
    logic la, lb;
    int   len;
    bounce = 5'b11101;
    repeat (2)  drive(1'b1, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 1'b0, 1'b0);
    repeat (10) drive(1'b0, 1'b1, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 1'b0);
    repeat (3)  drive(1'b0, 1'b1, 1'b0);
    repeat (8)  drive(1'b0, 1'b0, 1'b0);
    for (int i = 4; i >= 0; i--) drive(1'b0, bounce[i], 1'b0);
    repeat (8)  drive(1'b0, 1'b0, 1'b0);
    repeat (30) drive(1'b0, 1'b1, 1'b1);
    repeat (10) drive(1'b0, 1'b0, 1'b0);
    repeat (15) drive(1'b0, 1'b1, 1'b1);
    repeat (12) drive(1'b0, 1'b1, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 1'b0);
    repeat (15) drive(1'b0, 1'b1, 1'b1);
    repeat (12) drive(1'b0, 1'b0, 1'b0);
    repeat (8)  drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    repeat (10) drive(1'b0, 1'b1, 1'b0);
    for (int s = 0; s < 200; s++) begin
      la  = 1'($urandom_range(0, 1));
      lb  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 25));
      for (int c = 0; c < len; c++)
        drive(1'($urandom_range(0, 299) == 0),
              la ^ 1'($urandom_range(0, 7) == 0),
              lb ^ 1'($urandom_range(0, 7) == 0));
    end
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
